// File: rtl/display_pkg.sv
// Shared display geometry, arbitration slot encoding and pixel address helpers.
// Latency: combinational helpers only.
// Backpressure: not applicable.
package display_pkg;

    localparam int H_ACTIVE = 640;
    localparam int V_ACTIVE = 480;
    localparam int PIX_W    = 12;
    localparam int VRAM_AW  = 19;
    localparam int ROW_W    = 9;
    localparam int COL_W    = 10;

    typedef enum logic [1:0] {
        SLOT_IDLE,
        SLOT_RD,
        SLOT_WR
    } slot_e;

    // row*640 + col as two shifts and adds, so no multiplier is inferred
    function automatic logic [VRAM_AW-1:0] pix_addr(input logic [ROW_W-1:0] row,
                                                    input logic [COL_W-1:0] col);
        logic [VRAM_AW-1:0] r;
        r = VRAM_AW'(row);
        return (r << 9) + (r << 7) + VRAM_AW'(col);
    endfunction

    function automatic logic pix_in_range(input logic [ROW_W-1:0] row,
                                          input logic [COL_W-1:0] col);
        return (row < ROW_W'(V_ACTIVE)) && (col < COL_W'(H_ACTIVE));
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Generic single-clock FIFO with occupancy count; DEPTH must be a power of two >= 2.
// Latency: pushed entry visible at pop_dat_o the cycle after push.
// Backpressure: push ignored while full, pop ignored while empty; caller watches full_o/empty_o.
module sync_fifo #(
    parameter  int DATA_W = 8,
    parameter  int DEPTH  = 4,
    localparam int AW     = $clog2(DEPTH),
    localparam int LW     = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push_i,
    input  logic [DATA_W-1:0] push_dat_i,
    input  logic              pop_i,
    output logic [DATA_W-1:0] pop_dat_o,
    output logic              full_o,
    output logic              empty_o,
    output logic [LW-1:0]     level_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wptr_q, wptr_d;
    logic [AW-1:0]     rptr_q, rptr_d;
    logic [LW-1:0]     level_q, level_d;
    logic              do_push, do_pop;

    assign full_o    = (level_q == LW'(DEPTH));
    assign empty_o   = (level_q == '0);
    assign level_o   = level_q;
    assign pop_dat_o = mem_q[rptr_q];
    assign do_push   = push_i && !full_o;
    assign do_pop    = pop_i && !empty_o;

    // Pointer and occupancy next state; simultaneous push/pop leaves the level unchanged
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        level_d = level_q;
        if (do_push) wptr_d = wptr_q + AW'(1);
        if (do_pop)  rptr_d = rptr_q + AW'(1);
        if (do_push && !do_pop)      level_d = level_q + LW'(1);
        else if (!do_push && do_pop) level_d = level_q - LW'(1);
    end

    // Control state; reset flushes the FIFO by clearing pointers and level
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            level_q <= level_d;
        end
    end

    // Storage needs no reset: entries are only read once counted in the level
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q] <= push_dat_i;
    end

endmodule

// File: rtl/vram_arbiter.sv
// Shares the single-port pixel RAM between scanout reads (absolute priority) and buffered writes.
// Latency: rd_valid 3 cycles after rd_req; a write reaches the RAM 2 cycles after acceptance when no read competes.
// Backpressure: wr_ready low while the write FIFO is full; reads are never stalled.
module vram_arbiter
    import display_pkg::*;
#(
    parameter int DATA_W     = PIX_W,
    parameter int ADDR_W     = VRAM_AW,
    parameter int FIFO_DEPTH = 4,
    parameter int STARVE_MAX = 1023
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             rd_req,
    input  logic [ROW_W-1:0]                 rd_row,
    input  logic [COL_W-1:0]                 rd_col,
    output logic [DATA_W-1:0]                rd_data,
    output logic                             rd_valid,
    input  logic                             wr_valid,
    output logic                             wr_ready,
    input  logic [ROW_W-1:0]                 wr_row,
    input  logic [COL_W-1:0]                 wr_col,
    input  logic [DATA_W-1:0]                wr_data,
    output logic [ADDR_W-1:0]                mem_addr,
    output logic                             mem_we,
    output logic [DATA_W-1:0]                mem_wdata,
    input  logic [DATA_W-1:0]                mem_rdata,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_level,
    output logic                             wr_starve
);

    localparam int CNT_W = $clog2(STARVE_MAX + 1);

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_ent_t;

    wr_ent_t           push_ent, head_ent;
    logic              fifo_full, fifo_empty, push, pop;
    logic              rd_in_range, wr_in_range;
    slot_e             slot;

    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              mem_we_q, mem_we_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              rd_v1_q, rd_ok1_q, rd_v2_q, rd_ok2_q;
    logic              rd_valid_q;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic [CNT_W-1:0]  starve_cnt_q, starve_cnt_d;
    logic              wr_starve_q, wr_starve_d;

    assign rd_in_range = pix_in_range(rd_row, rd_col);
    assign wr_in_range = pix_in_range(wr_row, wr_col);

    // Out-of-range writes complete the handshake but are dropped here
    assign wr_ready      = !rst && !fifo_full;
    assign push          = wr_valid && wr_ready && wr_in_range;
    assign push_ent.addr = ADDR_W'(pix_addr(wr_row, wr_col));
    assign push_ent.data = wr_data;

    sync_fifo #(
        .DATA_W ($bits(wr_ent_t)),
        .DEPTH  (FIFO_DEPTH)
    ) u_wr_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_i     (push),
        .push_dat_i (push_ent),
        .pop_i      (pop),
        .pop_dat_o  (head_ent),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty),
        .level_o    (fifo_level)
    );

    // Slot choice: any read request owns the cycle; an out-of-range read leaves the port idle
    always_comb begin
        slot = SLOT_IDLE;
        if (rd_req) begin
            if (rd_in_range) slot = SLOT_RD;
        end else if (!fifo_empty) begin
            slot = SLOT_WR;
        end
    end

    assign pop = (slot == SLOT_WR);

    // Next RAM port values; an idle cycle keeps the address and data but never writes
    always_comb begin
        mem_addr_d  = mem_addr_q;
        mem_we_d    = 1'b0;
        mem_wdata_d = mem_wdata_q;
        case (slot)
            SLOT_RD: mem_addr_d = ADDR_W'(pix_addr(rd_row, rd_col));
            SLOT_WR: begin
                mem_addr_d  = head_ent.addr;
                mem_we_d    = 1'b1;
                mem_wdata_d = head_ent.data;
            end
            default: ;
        endcase
    end

    // Returned pixel: RAM data for in-range reads, zero for out-of-range ones
    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_v2_q) rd_data_d = rd_ok2_q ? mem_rdata : '0;
    end

    // Starvation counter saturates at the limit; the flag is sticky until reset
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        wr_starve_d  = wr_starve_q;
        if (fifo_empty || pop)                      starve_cnt_d = '0;
        else if (starve_cnt_q != CNT_W'(STARVE_MAX)) starve_cnt_d = starve_cnt_q + CNT_W'(1);
        if (starve_cnt_d == CNT_W'(STARVE_MAX))     wr_starve_d  = 1'b1;
    end

    // Registered RAM port, read return pipeline and starvation state; reset kills in-flight reads
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_addr_q   <= '0;
            mem_we_q     <= 1'b0;
            mem_wdata_q  <= '0;
            rd_v1_q      <= 1'b0;
            rd_ok1_q     <= 1'b0;
            rd_v2_q      <= 1'b0;
            rd_ok2_q     <= 1'b0;
            rd_valid_q   <= 1'b0;
            rd_data_q    <= '0;
            starve_cnt_q <= '0;
            wr_starve_q  <= 1'b0;
        end else begin
            mem_addr_q   <= mem_addr_d;
            mem_we_q     <= mem_we_d;
            mem_wdata_q  <= mem_wdata_d;
            rd_v1_q      <= rd_req;
            rd_ok1_q     <= rd_req && rd_in_range;
            rd_v2_q      <= rd_v1_q;
            rd_ok2_q     <= rd_ok1_q;
            rd_valid_q   <= rd_v2_q;
            rd_data_q    <= rd_data_d;
            starve_cnt_q <= starve_cnt_d;
            wr_starve_q  <= wr_starve_d;
        end
    end

    assign mem_addr  = mem_addr_q;
    assign mem_we    = mem_we_q;
    assign mem_wdata = mem_wdata_q;
    assign rd_valid  = rd_valid_q;
    assign rd_data   = rd_data_q;
    assign wr_starve = wr_starve_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Scoreboarded bench for vram_arbiter with a synchronous RAM model.
// Latency: reads expected exactly 3 cycles after request; writes checked in push order.
// Backpressure: exercises full FIFO, read priority and starvation.
module tb_vram_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rd_req = 1'b0;
    logic [8:0]  rd_row = '0;
    logic [9:0]  rd_col = '0;
    logic [11:0] rd_data;
    logic        rd_valid;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [8:0]  wr_row = '0;
    logic [9:0]  wr_col = '0;
    logic [11:0] wr_data = '0;
    logic [18:0] mem_addr;
    logic        mem_we;
    logic [11:0] mem_wdata;
    logic [11:0] mem_rdata = '0;
    logic [2:0]  fifo_level;
    logic        wr_starve;

    vram_arbiter #(.STARVE_MAX(15)) dut (
        .clk(clk), .rst(rst),
        .rd_req(rd_req), .rd_row(rd_row), .rd_col(rd_col),
        .rd_data(rd_data), .rd_valid(rd_valid),
        .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_row(wr_row), .wr_col(wr_col), .wr_data(wr_data),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .fifo_level(fifo_level), .wr_starve(wr_starve)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous RAM model, read-before-write
    logic [11:0] ram [int];
    always @(posedge clk) begin
        mem_rdata <= ram.exists(int'(mem_addr)) ? ram[int'(mem_addr)] : 12'h000;
        if (mem_we) ram[int'(mem_addr)] = mem_wdata;
    end

    typedef struct {
        int          cyc;
        logic [11:0] d;
    } rexp_t;

    rexp_t       rq[$];
    logic [30:0] wq[$];
    logic [11:0] mdl [int];
    int          checks = 0;
    int          failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int ref_addr(input int r, input int c);
        return r * 640 + c;
    endfunction

    // Expected read result for a request driven in the current cycle
    task automatic exp_rd(input int r, input int c);
        rexp_t e;
        int    a;
        a     = ref_addr(r, c);
        e.cyc = cyc + 3;
        e.d   = (r < 480 && c < 640 && mdl.exists(a)) ? mdl[a] : 12'h000;
        rq.push_back(e);
    endtask

    // Expected RAM write for an in-range write accepted this cycle
    task automatic exp_wr(input int r, input int c, input logic [11:0] d);
        int a;
        a = ref_addr(r, c);
        mdl[a] = d;
        wq.push_back({19'(a), d});
    endtask

    rexp_t       mon_e;
    logic [30:0] mon_w;

    // Scoreboard: compares every read return and RAM write against the queues
    always @(negedge clk) begin
        if (!rst) begin
            if (rq.size() > 0 && rq[0].cyc < cyc) begin
                check("rd_missing", 32'd0, 32'd1);
                void'(rq.pop_front());
            end
            if (rd_valid) begin
                if (rq.size() == 0) check("rd_unexp", 32'd1, 32'd0);
                else begin
                    mon_e = rq.pop_front();
                    check("rd_cyc", cyc, mon_e.cyc);
                    check("rd_data", {20'd0, rd_data}, {20'd0, mon_e.d});
                end
            end
            if (mem_we) begin
                if (wq.size() == 0) check("wr_unexp", 32'd1, 32'd0);
                else begin
                    mon_w = wq.pop_front();
                    check("wr_addr", {13'd0, mem_addr}, {13'd0, mon_w[30:12]});
                    check("wr_data", {20'd0, mem_wdata}, {20'd0, mon_w[11:0]});
                end
            end
        end
    end

    initial begin
        // Reset values
        repeat (3) tick();
        check("rst_rd_valid", rd_valid, 0);
        check("rst_rd_data", rd_data, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_level", fifo_level, 0);
        check("rst_starve", wr_starve, 0);
        check("rst_wr_ready", wr_ready, 0);
        rst = 1'b0;
        #1;
        check("first_wr_ready", wr_ready, 1);

        // Idle after reset
        for (int i = 0; i < 20; i++) begin
            tick();
            check("idle_wr_ready", wr_ready, 1);
            check("idle_level", fifo_level, 0);
            check("idle_mem_we", mem_we, 0);
            check("idle_rd_valid", rd_valid, 0);
        end

        // Single write then read back
        wr_valid = 1'b1; wr_row = 9'd2; wr_col = 10'd5; wr_data = 12'hABC;
        check("sw_ready", wr_ready, 1);
        exp_wr(2, 5, 12'hABC);
        tick();
        wr_valid = 1'b0;
        check("sw_we_early", mem_we, 0);
        check("sw_level", fifo_level, 1);
        tick();
        check("sw_we", mem_we, 1);
        check("sw_addr", mem_addr, 1285);
        check("sw_wdata", mem_wdata, 12'hABC);
        check("sw_level0", fifo_level, 0);
        repeat (2) tick();
        rd_req = 1'b1; rd_row = 9'd2; rd_col = 10'd5;
        exp_rd(2, 5);
        tick();
        rd_req = 1'b0;
        check("sr_valid_early", rd_valid, 0);
        tick();
        check("sr_valid_early2", rd_valid, 0);
        tick();
        check("sr_valid", rd_valid, 1);
        check("sr_data", rd_data, 12'hABC);
        tick();
        check("sr_valid_off", rd_valid, 0);

        // Read priority with 4 writes pending, a 5th held by backpressure
        for (int i = 0; i < 13; i++) begin
            rd_req = 1'b1; rd_row = 9'd2; rd_col = 10'(i);
            exp_rd(2, i);
            wr_valid = 1'b1;
            if (i < 4) begin
                wr_row = 9'd20; wr_col = 10'(i); wr_data = 12'h100 + 12'(i);
                exp_wr(20, i, 12'h100 + 12'(i));
            end else begin
                wr_row = 9'd21; wr_col = 10'd7; wr_data = 12'h5A5;
            end
            check("prio_ready", wr_ready, (i < 4) ? 1 : 0);
            tick();
            check("prio_no_we", mem_we, 0);
            if (i >= 3) check("prio_level", fifo_level, 4);
        end
        rd_req = 1'b0;
        check("pop_cycle_ready", wr_ready, 0);
        tick();
        check("drain_we0", mem_we, 1);
        check("rise_ready", wr_ready, 1);
        check("drain_level0", fifo_level, 3);
        exp_wr(21, 7, 12'h5A5);
        tick();
        wr_valid = 1'b0;
        check("drain_we1", mem_we, 1);
        check("pushpop_level", fifo_level, 3);
        for (int j = 2; j < 5; j++) begin
            tick();
            check("drain_we", mem_we, 1);
        end
        tick();
        check("drain_done_we", mem_we, 0);
        check("drain_done_level", fifo_level, 0);
        check("no_starve_yet", wr_starve, 0);

        // Out-of-range write and read
        wr_valid = 1'b1; wr_row = 9'd480; wr_col = 10'd0; wr_data = 12'hFFF;
        check("oor_wr_ready", wr_ready, 1);
        tick();
        wr_valid = 1'b0;
        check("oor_wr_level", fifo_level, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("oor_wr_no_we", mem_we, 0);
        end
        rd_req = 1'b1; rd_row = 9'd0; rd_col = 10'd640;
        exp_rd(0, 640);
        tick();
        rd_req = 1'b0;
        check("oor_rd_addr_hold", mem_addr, ref_addr(21, 7));
        check("oor_rd_no_we", mem_we, 0);
        repeat (2) tick();
        check("oor_rd_valid", rd_valid, 1);
        check("oor_rd_data", rd_data, 0);
        repeat (3) tick();

        // Starvation: one write pending under a continuous read stream
        for (int i = 0; i < 20; i++) begin
            rd_req = 1'b1; rd_row = 9'd0; rd_col = 10'(i);
            exp_rd(0, i);
            if (i == 0) begin
                wr_valid = 1'b1; wr_row = 9'd30; wr_col = 10'd1; wr_data = 12'h777;
                check("stv_ready", wr_ready, 1);
                exp_wr(30, 1, 12'h777);
            end else begin
                wr_valid = 1'b0;
            end
            tick();
            if (i == 14) check("stv_before", wr_starve, 0);
            if (i == 15) check("stv_set", wr_starve, 1);
        end
        check("stv_level", fifo_level, 1);
        rd_req = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("stv_sticky", wr_starve, 1);
        end
        check("stv_drained", fifo_level, 0);

        // Reset during an in-flight read with a write just accepted
        rd_req = 1'b1; rd_row = 9'd0; rd_col = 10'd3;
        wr_valid = 1'b1; wr_row = 9'd40; wr_col = 10'd0; wr_data = 12'h321;
        tick();
        rd_req = 1'b0; wr_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_level", fifo_level, 0);
        check("mid_rst_starve", wr_starve, 0);
        check("mid_rst_we", mem_we, 0);
        for (int i = 0; i < 6; i++) begin
            tick();
            check("mid_rst_no_valid", rd_valid, 0);
            check("mid_rst_no_we", mem_we, 0);
        end

        repeat (3) tick();
        check("rq_empty", rq.size(), 0);
        check("wq_empty", wq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
